// File: rtl/dmem_responder_pkg.sv
// Shared widths, I/O page offsets and helpers for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmem_responder_pkg;

    localparam int unsigned DATA_BUS     = 32;
    localparam int unsigned MEM_ADDR_BUS = 32;
    localparam logic [DATA_BUS-1:0] DATA_INITIAL = '0;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Word offsets inside the 32-byte I/O page
    localparam logic [4:0] IO_LED     = 5'h00;
    localparam logic [4:0] IO_SW      = 5'h04;
    localparam logic [4:0] IO_TIMER   = 5'h08;
    localparam logic [4:0] IO_TIMECMP = 5'h0C;
    localparam logic [4:0] IO_CTRL    = 5'h10;

    // Which registered source drives rdata during the response cycle
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_IO   = 2'd2
    } rd_src_e;

    // Replace only the bytes whose enable bit is set
    function automatic logic [DATA_BUS-1:0] be_merge(
        input logic [DATA_BUS-1:0] old_w,
        input logic [DATA_BUS-1:0] new_w,
        input logic [3:0]          be
    );
        logic [DATA_BUS-1:0] m;
        m = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Free-running timer with compare, enable/pending control and interrupt level.
// Latency: register writes take effect at the request edge; int_out lags pend&en by one cycle.
// Backpressure: none; a write strobe is accepted every cycle.
module dmem_timer
    import dmem_responder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                timer_we,
    input  logic                timecmp_we,
    input  logic                ctrl_we,
    input  logic [3:0]          be,
    input  logic [DATA_BUS-1:0] wdata,
    output logic [DATA_BUS-1:0] timer_val,
    output logic [DATA_BUS-1:0] timecmp_val,
    output logic                ctrl_en,
    output logic                ctrl_pend,
    output logic                int_out
);

    logic [DATA_BUS-1:0] cnt_q, cnt_d;
    logic [DATA_BUS-1:0] cmp_q, cmp_d;
    logic                en_q, en_d;
    logic                pend_q, pend_d;
    logic                int_q, int_d;

    // Next-state: a software write to the counter beats the increment; a match beats W1C
    always_comb begin
        cnt_d  = cnt_q;
        cmp_d  = cmp_q;
        en_d   = en_q;
        pend_d = pend_q;
        int_d  = pend_q & en_q;
        if (timer_we) begin
            cnt_d = be_merge(cnt_q, wdata, be);
        end else if (en_q) begin
            cnt_d = cnt_q + 32'd1;
        end
        if (timecmp_we) cmp_d = be_merge(cmp_q, wdata, be);
        if (ctrl_we && be[0]) begin
            en_d = wdata[0];
            if (wdata[1]) pend_d = DISABLE;
        end
        if (en_q && (cnt_q == cmp_q)) pend_d = ENABLE;
    end

    // Timer state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            cmp_q  <= '1;
            en_q   <= DISABLE;
            pend_q <= DISABLE;
            int_q  <= DISABLE;
        end else begin
            cnt_q  <= cnt_d;
            cmp_q  <= cmp_d;
            en_q   <= en_d;
            pend_q <= pend_d;
            int_q  <= int_d;
        end
    end

    assign timer_val   = cnt_q;
    assign timecmp_val = cmp_q;
    assign ctrl_en     = en_q;
    assign ctrl_pend   = pend_q;
    assign int_out     = int_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-enabled RAM, LED/switch I/O page and timer behind the CPU load/store port.
// Latency: loads return rdata/rvalid one cycle after mem_r; stores commit at the request edge.
// Backpressure: none; a request is accepted every cycle, no stall path exists.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned            DEPTH_WORDS = 1024,
    parameter logic [MEM_ADDR_BUS-1:0] IO_BASE    = 32'hFFFF_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_r,
    input  logic                    mem_w,
    input  logic [MEM_ADDR_BUS-1:0] addr,
    input  logic [DATA_BUS-1:0]     wdata,
    input  logic [3:0]              dwea,
    output logic [DATA_BUS-1:0]     rdata,
    output logic                    rvalid,
    output logic                    addr_err,
    input  logic [15:0]             io_sw,
    output logic [15:0]             io_led,
    output logic                    int_out
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [MEM_ADDR_BUS:0] RAM_BYTES = (MEM_ADDR_BUS+1)'(DEPTH_WORDS * 4);

    logic                ram_hit, io_hit, misalign, bad;
    logic [AW-1:0]       ram_idx;
    logic [4:0]          io_off;
    logic                ram_we, ram_re, io_we;
    logic                led_we, timer_we, timecmp_we, ctrl_we;

    logic [DATA_BUS-1:0] ram_mem [DEPTH_WORDS];
    logic [DATA_BUS-1:0] ram_dout_q;

    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    rd_src_e             src_q, src_d;
    logic [DATA_BUS-1:0] io_rdata_q, io_rdata_d;
    logic [15:0]         led_q, led_d;
    logic [15:0]         sw_q, sw_d;

    logic [DATA_BUS-1:0] timer_val, timecmp_val;
    logic                ctrl_en, ctrl_pend;

    // Address decode and per-target strobes; requests during reset are dropped here
    always_comb begin
        ram_hit    = {1'b0, addr} < RAM_BYTES;
        io_hit     = addr[MEM_ADDR_BUS-1:5] == IO_BASE[MEM_ADDR_BUS-1:5];
        misalign   = addr[1:0] != 2'b00;
        bad        = misalign | ~(ram_hit | io_hit);
        ram_idx    = addr[AW+1:2];
        io_off     = addr[4:0];
        ram_we     = mem_w & ~rst & ram_hit & ~misalign;
        ram_re     = mem_r & ~rst & ram_hit & ~misalign;
        io_we      = mem_w & ~rst & io_hit & ~misalign;
        led_we     = io_we & (io_off == IO_LED);
        timer_we   = io_we & (io_off == IO_TIMER);
        timecmp_we = io_we & (io_off == IO_TIMECMP);
        ctrl_we    = io_we & (io_off == IO_CTRL);
    end

    // Byte-enabled block RAM with registered read; a same-edge read sees the old word
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dwea[b]) ram_mem[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (ram_re) ram_dout_q <= ram_mem[ram_idx];
    end

    // Response control, I/O read mux and LED/switch next-state
    always_comb begin
        rvalid_d   = mem_r & ~rst;
        err_d      = (mem_r | mem_w) & bad & ~rst;
        src_d      = SRC_ZERO;
        if (mem_r && !rst && !bad) src_d = ram_hit ? SRC_RAM : SRC_IO;
        case (io_off)
            IO_LED:     io_rdata_d = {16'h0, led_q};
            IO_SW:      io_rdata_d = {16'h0, sw_q};
            IO_TIMER:   io_rdata_d = timer_val;
            IO_TIMECMP: io_rdata_d = timecmp_val;
            IO_CTRL:    io_rdata_d = {30'h0, ctrl_pend, ctrl_en};
            default:    io_rdata_d = DATA_INITIAL;
        endcase
        led_d = led_q;
        if (led_we && dwea[0]) led_d[7:0]  = wdata[7:0];
        if (led_we && dwea[1]) led_d[15:8] = wdata[15:8];
        sw_d = io_sw;
    end

    // Response and I/O registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q   <= DISABLE;
            err_q      <= DISABLE;
            src_q      <= SRC_ZERO;
            io_rdata_q <= DATA_INITIAL;
            led_q      <= '0;
            sw_q       <= '0;
        end else begin
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            src_q      <= src_d;
            io_rdata_q <= io_rdata_d;
            led_q      <= led_d;
            sw_q       <= sw_d;
        end
    end

    // Select the registered source; bad or idle cycles read as zero
    always_comb begin
        case (src_q)
            SRC_RAM: rdata = ram_dout_q;
            SRC_IO:  rdata = io_rdata_q;
            default: rdata = DATA_INITIAL;
        endcase
    end

    assign rvalid   = rvalid_q;
    assign addr_err = err_q;
    assign io_led   = led_q;

    dmem_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .timer_we    (timer_we),
        .timecmp_we  (timecmp_we),
        .ctrl_we     (ctrl_we),
        .be          (dwea),
        .wdata       (wdata),
        .timer_val   (timer_val),
        .timecmp_val (timecmp_val),
        .ctrl_en     (ctrl_en),
        .ctrl_pend   (ctrl_pend),
        .int_out     (int_out)
    );

endmodule
